// File: rtl/fir_param_pkg.sv
// Shared definitions for the fir_param FIR filter: default-width sample and
// coefficient types, accumulator sizing and the round-half-up constant.
package fir_param_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;

    // Default-width views of a sample and a coefficient.
    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;

    // Accumulator width that holds the sum of ntaps full-width products without overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    // Half of one output LSB: added before the arithmetic shift to round half up.
    function automatic longint unsigned round_const(input int shift);
        return 64'd1 << (shift - 1);
    endfunction

endpackage

// File: rtl/fir_param_round_sat.sv
// Rounding, scaling and output clamp for fir_param (combinational).
// With FIR_PARAM_SAT_EN defined the scaled sum saturates to the DATA_W range
// and sat reports the clip; otherwise it wraps to its low DATA_W bits.
module fir_param_round_sat
    import fir_param_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 38,
    parameter int OUT_SHIFT = 15
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
`ifdef FIR_PARAM_SAT_EN
    ,
    output logic                     sat
`endif
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] RND = EXT_W'(round_const(OUT_SHIFT));

    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    assign rounded = EXT_W'(acc) + RND;
    assign shifted = rounded >>> OUT_SHIFT;

`ifdef FIR_PARAM_SAT_EN
    // The result fits when every bit from the output sign bit upward agrees.
    logic [EXT_W-DATA_W:0] hi;
    logic                  in_range;

    assign hi       = shifted[EXT_W-1:DATA_W-1];
    assign in_range = (&hi) | ~(|hi);
    assign sat      = ~in_range;
    assign y        = in_range          ? shifted[DATA_W-1:0] :
                      shifted[EXT_W-1]  ? {1'b1, {(DATA_W-1){1'b0}}} :
                                          {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign y = DATA_W'(shifted);
`endif

endmodule

// File: rtl/fir_param.sv
// Parameterised direct-form FIR filter with writable coefficients.
// Stage 1 registers all tap products, stage 2 registers the rounded/scaled
// sum: out_valid follows in_valid by exactly two cycles.
// Optional feature: define FIR_PARAM_SAT_EN for output saturation and the
// sat_flag port; without it the output wraps and sat_flag does not exist.
module fir_param
    import fir_param_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 8,
    parameter int OUT_SHIFT = 15
) (
    input  logic                       system1000,
    input  logic                       system1000_rstn,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   out_data
`ifdef FIR_PARAM_SAT_EN
    ,
    output logic                       sat_flag
`endif
);

    localparam int ADDR_W = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);

    logic signed [COEF_W-1:0] coef   [NTAPS];
    // hist[0] is the most recent accepted sample; the live input is tap 0.
    logic signed [DATA_W-1:0] hist   [NTAPS-1];
    logic signed [DATA_W-1:0] tap    [NTAPS];
    logic signed [PROD_W-1:0] prod_d [NTAPS];
    logic signed [PROD_W-1:0] prod_q [NTAPS];
    logic                     s1_valid;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] scaled;
    logic                     accept;
    logic                     s2_load;
`ifdef FIR_PARAM_SAT_EN
    logic                     sat_d;
`endif

    // Flush wins over a simultaneous sample.
    assign accept  = in_valid & ~flush;
    assign s2_load = s1_valid & ~flush;

    // Coefficient bank: an address matching no tap writes nothing.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            // NOTE: the coefficients are a small flop array, not a RAM, so they can and must reset to zero.
            for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
        end else if (coef_we) begin
            for (int k = 0; k < NTAPS; k++) begin
                // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
                if (coef_addr == ADDR_W'(k)) coef[k] <= coef_data;
            end
        end
    end

    // Delay line: shifts only on accepted samples, cleared by flush.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int k = 0; k < NTAPS-1; k++) hist[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < NTAPS-1; k++) hist[k] <= '0;
        end else if (in_valid) begin
            hist[0] <= in_data;
            for (int k = 1; k < NTAPS-1; k++) hist[k] <= hist[k-1];
        end
    end

    // Tap vector and products: the sample arriving now meets coef[0], and a
    // coefficient written this cycle is not yet visible here.
    always_comb begin
        tap[0] = in_data;
        for (int k = 1; k < NTAPS; k++) tap[k] = hist[k-1];
        for (int k = 0; k < NTAPS; k++) prod_d[k] = PROD_W'(coef[k]) * PROD_W'(tap[k]);
    end

    // Stage 1: register the products of each accepted sample.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < NTAPS; k++) prod_q[k] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                for (int k = 0; k < NTAPS; k++) prod_q[k] <= prod_d[k];
            end
        end
    end

    // Full-width sum of the registered products.
    always_comb begin
        // NOTE: acc gets a value before the loop (no latch) and accumulates with blocking '=' so each step sees the previous one.
        acc = '0;
        for (int k = 0; k < NTAPS; k++) acc = acc + ACC_W'(prod_q[k]);
    end

    fir_param_round_sat #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .acc (acc),
        .y   (scaled)
`ifdef FIR_PARAM_SAT_EN
        ,
        .sat (sat_d)
`endif
    );

    // Stage 2: registered output; out_data holds while no result is presented.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef FIR_PARAM_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            out_valid <= s2_load;
            if (s2_load) out_data <= scaled;
`ifdef FIR_PARAM_SAT_EN
            sat_flag  <= s2_load & sat_d;
`endif
        end
    end

endmodule

// File: doc/fir_param.md
FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 Parameter DATA_W, default 16: signed sample width of input and output.
REQ-002 Parameter COEF_W, default 16: signed coefficient width.
REQ-003 Parameter NTAPS, default 8, legal range 2..64: number of filter taps.
REQ-004 Parameter OUT_SHIFT, default 15, legal range 1..(COEF_W+DATA_W-2): right-shift that maps the accumulator to the output scale.
REQ-005 system1000  in  1: single clock; all state is rising-edge.
REQ-006 system1000_rstn  in  1: asynchronous reset, active-low.
REQ-007 in_valid  in  1: in_data is a sample this cycle.
REQ-008 in_data  in  DATA_W signed: input sample.
REQ-009 flush  in  1: synchronous clear of the delay line.
REQ-010 coef_we  in  1: coefficient write strobe.
REQ-011 coef_addr  in  $clog2(NTAPS): tap index to write; 0 is applied to the newest sample.
REQ-012 coef_data  in  COEF_W signed: coefficient value.
REQ-013 out_valid  out  1: out_data holds a filtered sample.
REQ-014 out_data  out  DATA_W signed: filtered sample.
REQ-015 sat_flag  out  1: out_data was clipped this cycle (present only with the macro, see REQ-031).

Function
REQ-016 The delay line shall shift by one sample only in cycles where in_valid=1; when in_valid=0 it holds its contents.
REQ-017 For each accepted sample, y = sum over k of coef[k]*x[n-k]; the accumulator width shall be DATA_W+COEF_W+$clog2(NTAPS), with no intermediate overflow.
REQ-018 Pipeline stage 1 shall register all NTAPS products; stage 2 shall register the sum after rounding and scaling; latency from in_valid to out_valid shall be exactly 2 cycles.
REQ-019 out_valid shall be in_valid delayed by 2 cycles; out_data shall hold its last value while out_valid=0.
REQ-020 Rounding shall add 2^(OUT_SHIFT-1) to the sum and then shift right arithmetically by OUT_SHIFT (round-half-up).
REQ-021 A coef_we write shall take effect for samples accepted in the next cycle; a sample accepted in the same cycle as a write shall use the old coefficient.
REQ-022 Writes with coef_addr >= NTAPS shall be ignored.
REQ-023 flush=1 shall zero the delay line and the stage-1 and stage-2 valid bits next cycle; coefficients are unaffected.
REQ-024 If flush and in_valid are both 1, flush shall win and the sample shall be discarded.
REQ-025 There is no back-pressure: one sample is accepted per cycle at full rate.

Reset
REQ-026 While system1000_rstn=0, the delay line, all coefficients, both pipeline registers, out_valid, out_data and sat_flag shall be 0.
REQ-027 Assertion of reset mid-stream shall discard in-flight samples; the first in_valid after deassertion shall produce out_valid exactly 2 cycles later.

Configuration
REQ-028 Macro FIR_PARAM_SAT_EN shall select saturation of the scaled sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-029 With FIR_PARAM_SAT_EN defined, an out-of-range result shall clip, and sat_flag shall be 1 in the same cycle as that out_valid.
REQ-030 Without FIR_PARAM_SAT_EN, the scaled sum shall be truncated to its low DATA_W bits (two's-complement wrap).
REQ-031 Without FIR_PARAM_SAT_EN, sat_flag shall not exist as a port.

Structure
REQ-032 Package fir_param_pkg shall hold the accumulator-width function, the rounding-constant function and the sample/coef typedefs.
REQ-033 Sub-module fir_param_round_sat shall implement rounding, shift and saturate/wrap as combinational logic feeding the stage-2 register.

Verification
REQ-034 Impulse: coef[0]=16384 (others 0); in_data=32767 for 1 cycle, then 0 -> out_data=16384 after 2 cycles, then 0.
REQ-035 Tap order: coef[k]=1024*(k+1); unit impulse in_data=32767 -> 8 consecutive outputs equal to round(32767*1024*(k+1)/32768), i.e. 1024, 2048, ... 8192.
REQ-036 Saturation: all coefs=32767; in_data held at 32767 for 8 valid cycles -> with macro, out_data=32767 and sat_flag=1; without macro, out_data equals the low 16 bits of the rounded, shifted sum. Negative case: in_data held at -32768 -> with macro, out_data=-32768.
REQ-037 Gaps and flush: in_valid toggled 1/0 -> outputs match a gap-free reference at 2-cycle latency; flush together with in_valid -> the sample is dropped and the next output uses an all-zero history.
REQ-038 Write collision: coef_we together with in_valid -> that sample uses the old coefficient and the next sample uses the new one; coef_addr=NTAPS -> no change.
REQ-039 Reset mid-stream: system1000_rstn pulsed low while data is in flight -> out_valid=0 and out_data=0 immediately, coefficients read back as 0 (impulse gives 0), and the first new sample gives out_valid 2 cycles later.
